// File: rtl/hex_scan_pkg.sv
// -----------------------------------------------------------------------------
// hex_scan_pkg
// Shared definitions for the seven-segment scan controller: default parameter
// values, active-low segment patterns ({a,b,c,d,e,f,g} = seg[6:0]), the slot
// phase type, a width helper and the shared hex-to-segment decode.
// -----------------------------------------------------------------------------
package hex_scan_pkg;

    localparam int DIGITS_DEF    = 4;
    localparam int TICK_DIV_DEF  = 50000;
    localparam int BLANK_CYC_DEF = 16;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0001100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    // Bit width needed to hold 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = width_of(TICK_DIV_DEF);
    localparam int IDX_W = width_of(DIGITS_DEF);

    // Active-low hex-to-seven-segment decode.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            4'hF:    s = SEG_F;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// -----------------------------------------------------------------------------
// hex_scan_timer
// Slot timing for the scan controller. cnt runs 0..TICK_DIV-1 inside a slot,
// idx selects the digit and advances on each cnt wrap.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   next_idx      digit index of the coming cycle
//   slot_drive    coming cycle is past the blanking interval of its slot
//   frame_done    high for the last cycle of slot DIGITS-1 (registered)
// -----------------------------------------------------------------------------
module hex_scan_timer
    import hex_scan_pkg::*;
#(
    parameter int DIGITS    = DIGITS_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic [width_of(DIGITS)-1:0] next_idx,
    output logic                        slot_drive,
    output logic                        frame_done
);

    localparam int CW = width_of(TICK_DIV);
    localparam int IW = width_of(DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] next_cnt_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] next_idx_s;
    logic          frame_done_r;

    // Next slot position: cnt wraps at TICK_DIV-1 and carries into idx.
    always_comb begin
        next_cnt_s = cnt_r + CW'(1);
        next_idx_s = idx_r;
        if (cnt_r == CNT_LAST) begin
            next_cnt_s = '0;
            if (idx_r == IDX_LAST) begin
                next_idx_s = '0;
            end else begin
                next_idx_s = idx_r + IW'(1);
            end
        end else begin
            next_idx_s = idx_r;
        end
    end

    // Position registers; frame_done is registered from the next position so it
    // coincides with the last cycle of the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= '0;
            idx_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            cnt_r        <= next_cnt_s;
            idx_r        <= next_idx_s;
            frame_done_r <= (next_cnt_s == CNT_LAST) && (next_idx_s == IDX_LAST);
        end
    end

    assign next_idx   = next_idx_s;
    assign slot_drive = (next_cnt_s >= CNT_BLANK);
    assign frame_done = frame_done_r;

endmodule

// File: rtl/hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hex_scan_ctrl
// Time-multiplexed scan controller for a common-anode seven-segment display.
// A word is accepted into a pending buffer and promoted to the active word on
// the frame_done cycle, so the display never changes mid-frame.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load_valid     load_data valid this cycle
//   load_ready     pending buffer empty
//   load_data      nibble i shown on digit i
//   lzb_en         leading-zero blanking enable
//   disp_en        0 keeps all anodes off while the scan keeps running
//   seg            active-low segments {a..g}
//   an             active-low digit anodes
//   frame_done     pulse on the last cycle of slot DIGITS-1
// -----------------------------------------------------------------------------
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int DIGITS    = DIGITS_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic                  lzb_en,
    input  logic                  disp_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IW = width_of(DIGITS);
    localparam int DW = 4 * DIGITS;

    logic [IW-1:0]     next_idx_s;
    logic              slot_drive_s;
    logic              frame_done_s;
    logic [DW-1:0]     active_r;
    logic [DW-1:0]     pending_r;
    logic              pending_full_r;
    logic              accept_s;
    logic              zero_acc_s;
    logic [DIGITS-1:0] tail_zero_s;
    logic              suppress_s;
    logic [3:0]        nibble_s;
    phase_e            phase_s;
    logic [6:0]        seg_next_s;
    logic [DIGITS-1:0] an_next_s;
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] an_r;

    hex_scan_timer #(
        .DIGITS    (DIGITS),
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_idx   (next_idx_s),
        .slot_drive (slot_drive_s),
        .frame_done (frame_done_s)
    );

    assign accept_s = load_valid & ~pending_full_r;

    // Double buffer: accept into pending, promote to active on frame_done.
    // An accept always lands in an empty pending buffer, so both arms never
    // compete in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_r       <= '0;
            pending_r      <= '0;
            pending_full_r <= 1'b0;
        end else if (accept_s) begin
            pending_r      <= load_data;
            pending_full_r <= 1'b1;
        end else if (frame_done_s && pending_full_r) begin
            active_r       <= pending_r;
            pending_r      <= '0;
            pending_full_r <= 1'b0;
        end
    end

    // tail_zero_s[i]: nibbles i..DIGITS-1 of the active word are all zero.
    always_comb begin
        zero_acc_s  = 1'b1;
        tail_zero_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc_s     = zero_acc_s & (active_r[4*i +: 4] == 4'h0);
            tail_zero_s[i] = zero_acc_s;
        end
    end

    // Output pattern for the coming cycle; digit 0 is exempt from zero blanking.
    always_comb begin
        nibble_s   = active_r[{next_idx_s, 2'b00} +: 4];
        phase_s    = slot_drive_s ? PH_DRIVE : PH_BLANK;
        suppress_s = ~disp_en |
                     (lzb_en & (next_idx_s != '0) & tail_zero_s[next_idx_s]);
        if ((phase_s == PH_DRIVE) && !suppress_s) begin
            seg_next_s = hex_to_seg(nibble_s);
            an_next_s  = ~(DIGITS'(1) << next_idx_s);
        end else begin
            seg_next_s = SEG_OFF;
            an_next_s  = '1;
        end
    end

    // Output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_r <= SEG_OFF;
            an_r  <= '1;
        end else begin
            seg_r <= seg_next_s;
            an_r  <= an_next_s;
        end
    end

    assign seg        = seg_r;
    assign an         = an_r;
    assign load_ready = ~pending_full_r;
    assign frame_done = frame_done_s;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_ctrl
// Self-checking bench for hex_scan_ctrl (DIGITS=4, TICK_DIV=8, BLANK_CYC=2).
// The reference model tracks the cycle number since reset release and derives
// slot, digit, phase and frame boundary arithmetically from it; the display
// words are kept as plain active/pending values.
// -----------------------------------------------------------------------------
module tb_hex_scan_ctrl;

    localparam int D  = 4;
    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FR = D * TD;

    logic        clk;
    logic        reset_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        lzb_en;
    logic        disp_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hex_scan_ctrl #(
        .DIGITS    (D),
        .TICK_DIV  (TD),
        .BLANK_CYC (BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .lzb_en     (lzb_en),
        .disp_en    (disp_en),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0]  seg_tab [16];
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_full;
    bit          m_disp;
    bit          m_lzb;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Expected outputs for cycle t, from the slot arithmetic and the active word.
    task automatic check_outputs();
        int         c;
        int         i;
        logic [3:0] nib;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        bit         sup;
        c       = t % TD;
        i       = (t / TD) % D;
        nib     = m_active[4*i +: 4];
        sup     = !m_disp || (m_lzb && (i > 0) && ((m_active >> (4*i)) == 16'h0000));
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        if ((c >= BC) && !sup) begin
            exp_an  = 4'hF & ~(4'b0001 << i);
            exp_seg = seg_tab[nib];
        end
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("seg", 32'(seg), 32'(exp_seg));
        check_eq("load_ready", 32'(load_ready), 32'(!m_full));
        check_eq("frame_done", 32'(frame_done), 32'((t % FR) == (FR - 1)));
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic cycle(input bit v, input logic [15:0] d, input bit le, input bit de,
                         output bit acc);
        load_valid = v;
        load_data  = d;
        lzb_en     = le;
        disp_en    = de;
        @(posedge clk);
        acc = v && !m_full;
        if (acc) begin
            m_pending = d;
            m_full    = 1'b1;
        end else if (((t % FR) == (FR - 1)) && m_full) begin
            m_active = m_pending;
            m_full   = 1'b0;
        end
        m_disp = de;
        m_lzb  = le;
        t++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit le, input bit de);
        bit acc;
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, 16'($urandom), le, de, acc);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_seg", 32'(seg), 32'(7'h7F));
        check_eq("rst_an", 32'(an), 32'(4'hF));
        check_eq("rst_load_ready", 32'(load_ready), 32'(1'b1));
        check_eq("rst_frame_done", 32'(frame_done), 32'(1'b0));
    endtask

    // Assert reset (now, or at the next falling edge), hold it, release it.
    task automatic do_reset(input bit immediate);
        if (!immediate) begin
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n   = 1'b1;
        t         = 0;
        m_active  = 16'h0000;
        m_pending = 16'h0000;
        m_full    = 1'b0;
        m_disp    = disp_en;
        m_lzb     = lzb_en;
        #1;
        check_outputs();
    endtask

    initial begin
        int          first_fd;
        int          n_fd;
        bit          acc;
        bit          le;
        bit          de;
        logic [15:0] d;
        logic [15:0] masks [5];

        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        masks   = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        lzb_en     = 1'b0;
        disp_en    = 1'b1;
        t          = 0;
        m_active   = 16'h0000;
        m_pending  = 16'h0000;
        m_full     = 1'b0;
        m_disp     = 1'b1;
        m_lzb      = 1'b0;

        // Reset and position of the first frame_done.
        do_reset(1'b0);
        first_fd = -1;
        for (int k = 0; (k < 2 * FR) && (first_fd < 0); k++) begin
            if (frame_done) begin
                first_fd = t;
            end else begin
                cycle(1'b0, 16'($urandom), 1'b0, 1'b1, acc);
            end
        end
        check_eq("first_frame_done_cycle", 32'(first_fd), 32'(FR - 1));

        // Single load shown from the next frame boundary.
        cycle(1'b1, 16'h1A3F, 1'b0, 1'b1, acc);
        idle(3 * FR, 1'b0, 1'b1);

        // Leading-zero blanking on and off.
        cycle(1'b1, 16'h0005, 1'b1, 1'b1, acc);
        idle(2 * FR, 1'b1, 1'b1);
        idle(FR, 1'b0, 1'b1);

        // Second word held while pending is full.
        cycle(1'b1, 16'h2222, 1'b0, 1'b1, acc);
        acc = 1'b0;
        for (int k = 0; (k < 3 * FR) && !acc; k++) begin
            cycle(1'b1, 16'hBEEF, 1'b0, 1'b1, acc);
        end
        load_valid = 1'b0;
        idle(3 * FR, 1'b0, 1'b1);

        // Display disabled: anodes off, frame_done keeps its rate.
        n_fd = 0;
        for (int k = 0; k < 2 * FR; k++) begin
            cycle(1'b0, 16'($urandom), 1'b0, 1'b0, acc);
            n_fd += int'(frame_done);
        end
        check_eq("frame_done_count_disp_off", 32'(n_fd), 32'(2));

        // Randomized traffic.
        le = 1'b0;
        de = 1'b1;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(15, 0) == 0) le = ~le;
            if ($urandom_range(19, 0) == 0) de = ~de;
            d = 16'($urandom) & masks[$urandom_range(4, 0)];
            cycle($urandom_range(3, 0) == 0, d, le, de, acc);
        end

        // Reset in the drive phase of digit 2.
        for (int k = 0; (k < FR) && !(((t / TD) % D == 2) && ((t % TD) >= BC + 1)); k++) begin
            cycle(1'b0, 16'($urandom), 1'b0, 1'b1, acc);
        end
        check_eq("pre_reset_an_digit2", 32'(an), 32'(4'b1011));
        do_reset(1'b1);
        idle(2 * FR, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
